// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and default sizes for the two-requester RAM port arbiter.
package ram_arb_pkg;

    localparam int DATA_W_DEFAULT = 9;
    localparam int ADDR_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef logic req_id_t;

    function automatic logic [1:0] id_onehot(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the one not granted last.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       winner_o
);

    always_comb begin
        winner_o = 1'b0;
        if (req_i == 2'b11) begin
            winner_o = ~last_grant_i;
        end else if (req_i[1]) begin
            winner_o = 1'b1;
        end
        grant_o = (req_i == 2'b00) ? 2'b00 : id_onehot(winner_o);
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises read/write requests from two masters onto one single-port RAM;
// each accepted request gets a response exactly three cycles after its accept.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    arb_state_e         state_q;
    req_id_t            last_grant_q;
    req_id_t            owner_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               ram_cs_q;
    logic               ram_we_q;
    logic [1:0]         rsp_vld_q;

    logic [1:0]         grant;
    logic               winner;
    logic               accept;
    logic               we_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;

    rr_arb2 u_rr_arb2 (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .winner_o     (winner)
    );

    // Request fields of the current winner, latched on the accepting edge.
    always_comb begin
        we_d    = winner ? req_we[1] : req_we[0];
        addr_d  = winner ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
        wdata_d = winner ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
        accept  = (state_q == IDLE) && (grant != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            rsp_vld_q    <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q      <= ISSUE;
                        last_grant_q <= winner;
                        owner_q      <= winner;
                        we_q         <= we_d;
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        ram_cs_q     <= 1'b1;
                        ram_we_q     <= we_d;
                    end
                end
                ISSUE: begin
                    state_q  <= WAIT;
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                end
                // RAM read data is valid during WAIT, one cycle after the strobe.
                WAIT: begin
                    state_q   <= RESP;
                    rsp_vld_q <= id_onehot(owner_q);
                    if (!we_q) begin
                        rdata_q <= ram_rdata;
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    rsp_vld_q <= 2'b00;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs are forced low for the whole time reset is held.
    assign req_ready = (state_q == IDLE && !rst) ? grant : 2'b00;
    assign rsp_valid = rst ? 2'b00 : rsp_vld_q;
    assign rsp_rdata = rdata_q;
    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: external RAM model, latency-based reference model,
// directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

    localparam int DW = 9;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_we = 2'b00;
    logic [2*AW-1:0]   req_addr = '0;
    logic [2*DW-1:0]   req_wdata = '0;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              ram_cs;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata = '0;

    ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // External single-port RAM: read data appears the cycle after the strobe.
    logic [DW-1:0] ram_mem [16] = '{default: '0};
    always @(posedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (ram_cs && !ram_we) ram_rdata <= ram_mem[ram_addr];
    end

    // Reference model state: cycle index, accept cycle of the live transaction,
    // shadow memory updated in accept order (accesses are fully serialised).
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            acc = -100;
    bit            m_last = 1'b1;
    bit            m_owner = 1'b0;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdval = '0;
    logic [DW-1:0] m_rsp_data = '0;
    logic [DW-1:0] shadow [16] = '{default: '0};
    int            g_id [$];
    int            g_cyc [$];
    int            rsp_cnt [2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int exp_winner(input logic [1:0] v, input bit last);
        if (v == 2'b11) return last ? 0 : 1;
        if (v[1]) return 1;
        if (v[0]) return 0;
        return -1;
    endfunction

    // One clock cycle: compare outputs mid-cycle, apply the edge to the model, advance.
    task automatic tick();
        int d;
        int w;
        logic [1:0] exp_rdy;
        logic [1:0] exp_rsp;
        @(negedge clk);
        d = cyc - acc;
        w = (!rst && d >= 4) ? exp_winner(req_valid, m_last) : -1;
        exp_rdy = (w < 0) ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01);
        exp_rsp = (!rst && d == 3) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        chk("ram_cs", 32'(ram_cs), 32'(d == 1));
        chk("ram_we", 32'(ram_we), 32'(d == 1 && m_we));
        if (d == 1) begin
            chk("ram_addr", 32'(ram_addr), 32'(m_addr));
            chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
        end
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rsp_data));
        if (rsp_valid[0]) rsp_cnt[0]++;
        if (rsp_valid[1]) rsp_cnt[1]++;
        if (rst) begin
            acc = -100;
            m_last = 1'b1;
            m_rsp_data = '0;
        end else begin
            if (d == 2 && !m_we) m_rsp_data = m_rdval;
            if (w >= 0) begin
                acc = cyc;
                m_owner = w[0];
                m_last = w[0];
                m_we = req_we[w];
                m_addr = req_addr[w*AW +: AW];
                m_wdata = req_wdata[w*DW +: DW];
                if (m_we) shadow[m_addr] = m_wdata;
                else m_rdval = shadow[m_addr];
                g_id.push_back(w);
                g_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Present one request and tick until it is accepted (bounded); returns in cycle 1.
    task automatic do_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] dat);
        int n0;
        n0 = g_id.size();
        req_valid[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = dat;
        for (int k = 0; k < 20 && g_id.size() == n0; k++) tick();
        req_valid[i] = 1'b0;
        chk("accept_seen", 32'(g_id.size() > n0), 32'd1);
    endtask

    initial begin
        int n0;
        int c0;
        int c1;

        // Reset held for two checked cycles after an initial settling edge.
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_ram_cs", 32'(ram_cs), 32'd0);

        // First tie after reset favours requester 0.
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("first_tie", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        tick();

        // Single write then read from requester 0.
        do_req(0, 1'b1, 4'h3, 9'h1A5);
        chk("wr_ram_cs_c1", 32'(ram_cs), 32'd1);
        chk("wr_ram_we_c1", 32'(ram_we), 32'd1);
        chk("wr_ram_addr_c1", 32'(ram_addr), 32'h3);
        chk("wr_ram_wdata_c1", 32'(ram_wdata), 32'h1A5);
        tick();
        tick();
        chk("wr_rsp_c3", 32'(rsp_valid), 32'h1);
        tick();
        do_req(0, 1'b0, 4'h3, 9'h000);
        tick();
        tick();
        chk("rd_rsp_c3", 32'(rsp_valid), 32'h1);
        chk("rd_data_c3", 32'(rsp_rdata), 32'h1A5);
        tick();

        // Requester 1 writes 0xF; leaves last grant at 1 for the contention run.
        do_req(1, 1'b1, 4'hF, 9'h0FF);
        repeat (3) tick();

        // Contention: both hold valid for four accepts.
        n0 = g_id.size();
        c0 = rsp_cnt[0];
        c1 = rsp_cnt[1];
        req_valid = 2'b11;
        req_we = 2'b00;
        req_addr = {4'h2, 4'h3};
        for (int k = 0; k < 40 && g_id.size() < n0 + 4; k++) tick();
        req_valid = 2'b00;
        repeat (3) tick();
        chk("cont_accepts", 32'(g_id.size() - n0), 32'd4);
        for (int k = 0; k < 4 && n0 + k < g_id.size(); k++) begin
            chk("cont_grant", 32'(g_id[n0+k]), 32'(k % 2));
            if (k > 0) chk("cont_spacing", 32'(g_cyc[n0+k] - g_cyc[n0+k-1]), 32'd4);
        end
        chk("cont_rsp0", 32'(rsp_cnt[0] - c0), 32'd2);
        chk("cont_rsp1", 32'(rsp_cnt[1] - c1), 32'd2);

        // Cross-requester read-after-write.
        do_req(0, 1'b0, 4'hF, 9'h000);
        tick();
        tick();
        chk("raw_rsp", 32'(rsp_valid), 32'h1);
        chk("raw_data", 32'(rsp_rdata), 32'h0FF);
        tick();

        // Reset during WAIT of a read: that read never responds.
        do_req(1, 1'b0, 4'h3, 9'h000);
        tick();
        rst = 1'b1;
        c0 = rsp_cnt[0];
        c1 = rsp_cnt[1];
        tick();
        rst = 1'b0;
        chk("midrst_rdata", 32'(rsp_rdata), 32'd0);
        repeat (5) tick();
        chk("midrst_no_rsp", 32'(rsp_cnt[0] + rsp_cnt[1]), 32'(c0 + c1));
        req_valid = 2'b11;
        #1;
        chk("midrst_tie", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        tick();

        // Withdrawn request from requester 1 while requester 0 is busy.
        do_req(0, 1'b1, 4'h5, 9'h133);
        n0 = g_id.size();
        c1 = rsp_cnt[1];
        req_valid[1] = 1'b1;
        req_we[1] = 1'b1;
        req_addr[AW +: AW] = 4'h5;
        req_wdata[DW +: DW] = 9'h0AA;
        tick();
        req_valid[1] = 1'b0;
        repeat (6) tick();
        chk("wd_no_grant", 32'(g_id.size()), 32'(n0));
        chk("wd_no_rsp1", 32'(rsp_cnt[1]), 32'(c1));
        do_req(0, 1'b0, 4'h5, 9'h000);
        tick();
        tick();
        chk("wd_rd_rsp", 32'(rsp_valid), 32'h1);
        chk("wd_rd_data", 32'(rsp_rdata), 32'h133);
        tick();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_we = 2'($urandom_range(0, 3));
            req_addr = 8'($urandom);
            req_wdata = 18'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        req_valid = 2'b00;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
